// File: rtl/srl_sra_seq_alu.sv
// Iterative right shifter (SRL/SRA): one binary shift stage per clock, start/busy/done
// handshake, results on the shared s/of/cary/eq ALU result bus.
module srl_sra_seq_alu #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             arith,
  input  logic [WIDTH-1:0] a,
  input  logic [31:0]      b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             of,
  output logic             cary,
  output logic             eq
);

  localparam int KW = (STAGES > 1) ? $clog2(STAGES) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic [STAGES-1:0] amt_q, amt_d;
  logic [KW-1:0]     k_q, k_d;
  logic              arith_q, arith_d;
  logic              cary_pend_q, cary_pend_d;
  logic              cary_q, cary_d;
  logic              eq_q, eq_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              big;
  logic [WIDTH-1:0]  fill;
  logic [STAGES-1:0] last_idx;
  logic              cary_acc;
  logic [WIDTH-1:0]  stage_out;

  // Amounts >= WIDTH preload the accumulator with fill bits; the stages then leave it unchanged.
  always_comb begin
    big      = |b[31:STAGES];
    fill     = arith ? {WIDTH{a[WIDTH-1]}} : '0;
    last_idx = b[STAGES-1:0] - STAGES'(1);
    if (b == '0)
      cary_acc = 1'b0;
    else if (b <= 32'(WIDTH))
      cary_acc = a[last_idx];
    else
      cary_acc = fill[0];
  end

  always_comb begin
    stage_out = acc_q;
    if (amt_q[k_q]) begin
      if (arith_q)
        stage_out = $unsigned($signed(acc_q) >>> (1 << k_q));
      else
        stage_out = acc_q >> (1 << k_q);
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    s_d         = s_q;
    amt_d       = amt_q;
    k_d         = k_q;
    arith_d     = arith_q;
    cary_pend_d = cary_pend_q;
    cary_d      = cary_q;
    eq_d        = eq_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_SHIFT;
          acc_d       = big ? fill : a;
          amt_d       = b[STAGES-1:0];
          arith_d     = arith;
          cary_pend_d = cary_acc;
          k_d         = '0;
          busy_d      = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        acc_d = stage_out;
        if (k_q == KW'(STAGES - 1)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          s_d     = stage_out;
          cary_d  = cary_pend_q;
          eq_d    = (stage_out == '0);
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      s_q         <= '0;
      amt_q       <= '0;
      k_q         <= '0;
      arith_q     <= 1'b0;
      cary_pend_q <= 1'b0;
      cary_q      <= 1'b0;
      eq_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      s_q         <= s_d;
      amt_q       <= amt_d;
      k_q         <= k_d;
      arith_q     <= arith_d;
      cary_pend_q <= cary_pend_d;
      cary_q      <= cary_d;
      eq_q        <= eq_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign cary = cary_q;
  assign eq   = eq_q;
  assign of   = 1'b0;

endmodule
